// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } dcache_state_e;

    // Tag is held zero-extended to 32 bits so the struct does not depend on LINES.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] data;
    } line_t;

    // Byte enables for a store: one-hot lane for sb, all lanes for a word.
    function automatic logic [3:0] be_from_offset(input logic sb, input logic [1:0] off);
        if (sb) begin
            be_from_offset = 4'b0001 << off;
        end else begin
            be_from_offset = 4'b1111;
        end
    endfunction

endpackage

// File: rtl/dcache_wt_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read,
// synchronous byte-enabled write, valid bits cleared asynchronously on reset.
module dcache_wt_array
    import dcache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_tag,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid_q;
    logic [31:0]      tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // Valid bits: cleared on reset, set by any write to the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; data is written per byte lane.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Combinational read port.
    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_q[rd_idx];
        rd_line.tag   = tag_mem[rd_idx];
        rd_line.data  = data_mem[rd_idx];
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits complete in the same cycle; read misses and all stores stall
// the core over a req/ack handshake to backing memory.
// Optional hit/miss counters are built when DCACHE_WT_STATS_EN is defined.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic              cpu_sb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef DCACHE_WT_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);

    dcache_state_e     state;
    line_t             rd_line;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       tag_ext;
    logic              hit;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       rdata_q;
    logic              wr_en;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              rd_req;

    // Address decode, hit detection and store lane formatting.
    always_comb begin
        idx       = cpu_addr[IDX_W+1:2];
        tag_ext   = 32'(cpu_addr[ADDR_W-1:IDX_W+2]);
        hit       = rd_line.valid && (rd_line.tag == tag_ext);
        st_be     = be_from_offset(cpu_sb, cpu_addr[1:0]);
        st_wdata  = cpu_sb ? {4{cpu_wdata[7:0]}} : cpu_wdata;
        word_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
        // A simultaneous load and store is handled as the store.
        rd_req    = cpu_re && !cpu_we;
    end

    // Array writes: store-hit merge on leaving IDLE, line fill on read ack.
    always_comb begin
        wr_en   = 1'b0;
        wr_be   = st_be;
        wr_data = st_wdata;
        if (state == IDLE && cpu_we && hit) begin
            wr_en = 1'b1;
        end else if (state == RD_MISS && mem_ack) begin
            wr_en   = 1'b1;
            wr_be   = 4'b1111;
            wr_data = mem_rdata;
        end
    end

    dcache_wt_array #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (idx),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_tag  (tag_ext),
        .wr_be   (wr_be),
        .wr_data (wr_data)
    );

    // Stall and load data are combinational so hits and acks cost no extra cycle.
    always_comb begin
        stall     = 1'b0;
        cpu_rdata = rdata_q;
        if (state == IDLE) begin
            stall = cpu_we || (cpu_re && !hit);
            if (rd_req && hit) begin
                cpu_rdata = rd_line.data;
            end
        end else begin
            stall = !mem_ack;
            if (state == RD_MISS && mem_ack) begin
                cpu_rdata = mem_rdata;
            end
        end
        // Reset abandons any transaction and releases the core at once.
        if (reset) begin
            stall = 1'b0;
        end
    end

    // Control FSM with registered backing-memory request and held load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_we) begin
                        state     <= WR_THRU;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_be    <= st_be;
                        mem_addr  <= word_addr;
                        mem_wdata <= st_wdata;
                    end else if (cpu_re) begin
                        if (hit) begin
                            rdata_q <= rd_line.data;
                        end else begin
                            state    <= RD_MISS;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_be   <= 4'b1111;
                            mem_addr <= word_addr;
                        end
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_be  <= 4'b0000;
                        rdata_q <= mem_rdata;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_WT_STATS_EN
    // Saturating load hit/miss counters; stores are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && rd_req) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else if (miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the mips core's memory stage and a multi-cycle backing data memory.
- Replaces the single-cycle dmem path.
- Read hits return data in the same cycle with no stall.
- Read misses and all stores stall the core through a req/ack handshake to backing memory.
- Supports word and store-byte (sbM) writes.

Parameters:
- LINES, 16, number of one-word cache lines; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_re  in  1  load request in memory stage
- cpu_we  in  1  store request (memwrite)
- cpu_sb  in  1  store is a byte (sb); ignored unless cpu_we=1
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data; byte stores use bits [7:0]
- cpu_rdata  out  32  load data
- stall  out  1  core must hold the memory stage and all cpu_* inputs stable
- mem_req  out  1  backing-memory request
- mem_we  out  1  1=write, 0=read
- mem_be  out  4  byte enables; bit i is bits [8i+7:8i]
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0
- mem_wdata  out  32  write data, byte replicated into lane for sb
- mem_ack  in  1  one-cycle pulse: request done; read data valid this cycle
- mem_rdata  in  32  read data

Behaviour:
- Address split: offset [1:0]; index [log2(LINES)+1:2]; tag = the remaining upper bits.
- Per-line storage: valid bit, tag, 32-bit data.
- Reset (async):
  - All valid bits cleared; FSM goes to IDLE.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, stall=0, cpu_rdata=0.
  - Data and tag arrays are not cleared.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - cpu_re=1 and hit: cpu_rdata = line data combinationally; stall=0. Zero-latency hit.
  - cpu_re=1 and miss: stall=1 combinationally; next state RD_MISS.
  - cpu_we=1: stall=1 combinationally; next state WR_THRU.
  - cpu_re and cpu_we both 1: treated as a store.
  - Neither asserted: stall=0; cpu_rdata holds its last value.
- RD_MISS:
  - mem_req=1, mem_we=0, mem_be=4'b1111, mem_addr={cpu_addr[ADDR_W-1:2],2'b00}; stall=1.
  - On mem_ack: line filled (valid=1, tag, data=mem_rdata); cpu_rdata=mem_rdata that cycle; stall=0 that cycle; next state IDLE.
  - Miss latency = backing latency + 1 cycle.
- WR_THRU:
  - mem_req=1, mem_we=1.
  - Word store: mem_be=4'b1111.
  - Byte store: mem_be=one-hot on cpu_addr[1:0]; mem_wdata={4{cpu_wdata[7:0]}}.
  - Line update at state entry if hit: word store replaces the line; byte store merges the addressed byte only.
  - Store miss leaves the cache unchanged (no allocate).
  - On mem_ack: stall=0 that cycle; next state IDLE.
- Requests are only accepted in IDLE; inputs are stable while stall=1.
- mem_req stays high until mem_ack; the request never changes while pending.
- mem_ack outside RD_MISS/WR_THRU is ignored.
- Reset asserted mid-transaction: the transaction is abandoned and mem_req drops immediately. The backing memory must tolerate an abandoned request.
- Load after store to the same word returns the merged data (hit) or re-fetches (store miss).

Optional Feature:
- Macro: DCACHE_WT_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0]; both reset to 0.
  - hit_cnt increments on each IDLE read hit.
  - miss_cnt increments on each IDLE->RD_MISS transition.
  - Both saturate at 32'hFFFF_FFFF.
  - Stores are not counted.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum dcache_state_e {IDLE, RD_MISS, WR_THRU}
  - line struct {valid, tag, data}
  - function be_from_offset(sb, off) returning the 4-bit enable
- Sub-module dcache_wt_array holds the valid/tag/data storage:
  - combinational read port
  - synchronous write port with per-byte write enable
  - asynchronous valid clear on reset
- FSM and handshake logic stay in dcache_wt.

Test Plan:
- Cold load: cpu_re @0x40, backing returns 0xDEADBEEF after 3 cycles -> stall high 4 cycles, cpu_rdata=0xDEADBEEF; repeat load -> hit, stall=0, same data.
- Word store hit: after fill at 0x40, store 0x12345678 -> mem_be=1111, mem_addr=0x40; stall until ack; next load 0x40 returns 0x12345678 with no stall.
- Byte store: sb 0xAB to 0x42 on line holding 0x12345678 -> mem_be=0100, mem_wdata=0xABABABAB; load 0x40 -> 0x12AB5678.
- Conflict: LINES=16, load 0x40 then 0x80 (same index 0, different tag) -> second is a miss; reload 0x40 -> miss again.
- Store miss: sb to 0x100 uncached -> memory written; following load 0x100 misses and fetches.
- Reset mid RD_MISS: assert reset during pending read -> mem_req=0 and stall=0 immediately, all lines invalid; with DCACHE_WT_STATS_EN defined, counters read 0.
